// File: rtl/editor_campos_rtc_pkg.sv
// rtc_pkg
// Shared definitions for the BCD field editor that sits between the button
// debouncers and the RTC bus writer.
//   - field index constants for the nine time/date/timer fields
//   - default per-field limits and the mask of hour fields
//   - editor state enumeration
//   - BCD step helpers and 24 h -> 12 h display conversion
package rtc_pkg;

   localparam int SEG    = 0;
   localparam int MIN    = 1;
   localparam int HORA   = 2;
   localparam int DIA    = 3;
   localparam int MES    = 4;
   localparam int ANO    = 5;
   localparam int SEG_T  = 6;
   localparam int MIN_T  = 7;
   localparam int HORA_T = 8;

   localparam int          N_CAMPOS_DEF  = 9;
   localparam logic [71:0] LIM_MAX_DEF   = 72'h23_59_59_99_12_31_23_59_59;
   localparam logic [71:0] LIM_MIN_DEF   = 72'h00_00_00_00_01_01_00_00_00;
   localparam logic [8:0]  HORA_MASK_DEF = 9'b100000100;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EDIT   = 2'd1,
      COMMIT = 2'd2
   } estado_t;

   function automatic logic bcd_valido(input logic [7:0] v);
      return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
   endfunction

   // Anything that is not valid BCD or lies outside [mn, mx] snaps to mn,
   // so a corrupt RTC value can always be recovered with one press.
   function automatic logic [7:0] bcd_inc(input logic [7:0] v,
                                          input logic [7:0] mn,
                                          input logic [7:0] mx);
      logic [7:0] r;
      if (!bcd_valido(v) || (v < mn) || (v >= mx)) r = mn;
      else if (v[3:0] == 4'd9)                    r = {v[7:4] + 4'd1, 4'd0};
      else                                         r = {v[7:4], v[3:0] + 4'd1};
      return r;
   endfunction

   // Mirror image of bcd_inc: out-of-range or corrupt values snap to mx.
   function automatic logic [7:0] bcd_dec(input logic [7:0] v,
                                          input logic [7:0] mn,
                                          input logic [7:0] mx);
      logic [7:0] r;
      if (!bcd_valido(v) || (v <= mn) || (v > mx)) r = mx;
      else if (v[3:0] == 4'd0)                    r = {v[7:4] - 4'd1, 4'd9};
      else                                         r = {v[7:4], v[3:0] - 4'd1};
      return r;
   endfunction

   // Returns {pm, hour_bcd}. Values that are not a 00..23 hour pass through
   // unchanged and flagged AM.
   function automatic logic [8:0] bcd_a_12h(input logic [7:0] h);
      logic [8:0] r;
      r = {1'b0, h};
      if (h == 8'h00)                     r = {1'b0, 8'h12};
      else if (h == 8'h12)                r = {1'b1, 8'h12};
      else if (h >= 8'h13 && h <= 8'h19)  r = {1'b1, 4'h0, h[3:0] - 4'd2};
      else if (h == 8'h20 || h == 8'h21)  r = {1'b1, 4'h0, h[3:0] + 4'd8};
      else if (h == 8'h22 || h == 8'h23)  r = {1'b1, 4'h1, h[3:0] - 4'd2};
      return r;
   endfunction

endpackage

// File: rtl/editor_campos_rtc_repetidor_boton.sv
// repetidor_boton
// Turns a debounced button level into single-cycle step requests: one on the
// rising edge, another after REP_DELAY held cycles, then one every REP_RATE
// cycles while the button stays down.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   boton_i     - debounced button level
//   paso_o      - step request, valid in the cycle it is asserted
module repetidor_boton #(
   parameter int REP_DELAY = 50_000_000,
   parameter int REP_RATE  = 10_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic boton_i,
   output logic paso_o
);

   localparam int MAXC = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
   localparam int CW   = $clog2(MAXC + 1);

   logic          boton_q;
   logic [CW-1:0] cnt_q;
   logic          rep_q;
   logic          sube;
   logic          sostenido;
   logic          llega;

   // cnt_q holds how many cycles have passed since the last step; rep_q
   // tells whether we are still in the initial delay or already repeating.
   always_comb begin
      sube      = boton_i & ~boton_q;
      sostenido = boton_i & boton_q;
      llega     = sostenido && (rep_q ? (cnt_q == CW'(REP_RATE))
                                      : (cnt_q == CW'(REP_DELAY)));
      paso_o    = sube | llega;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         boton_q <= 1'b0;
         cnt_q   <= '0;
         rep_q   <= 1'b0;
      end else begin
         boton_q <= boton_i;
         if (sube) begin
            cnt_q <= CW'(1);
            rep_q <= 1'b0;
         end else if (llega) begin
            cnt_q <= CW'(1);
            rep_q <= 1'b1;
         end else if (sostenido) begin
            cnt_q <= cnt_q + CW'(1);
         end else begin
            cnt_q <= '0;
            rep_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/editor_campos_rtc.sv
// editor_campos_rtc
// N-field BCD time/date/timer editor. Loads the live RTC values when the
// config switch goes up, lets the user step fields and move a one-hot cursor,
// then hands the edited values to the RTC writer with a req/ack handshake.
// Also drives the VGA field bus with live or edited values, optionally in
// 12 h format.
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   en_escr               - config switch level, 1 = edit
//   aumenta, disminuye    - step up / step down buttons (auto-repeat)
//   corre_der, corre_izq  - cursor buttons (edge only)
//   doce_24               - 1 = show hour fields in 12 h format
//   rtc_in                - live RTC fields, 8 bits BCD each
//   wr_ack                - writer accepted campos_out
//   campos_out            - edited fields, 24 h BCD
//   vga_out, pm_out       - display fields and per-field PM flag
//   cursor                - one-hot selected field, zero outside edit
//   wr_req                - commit request
module editor_campos_rtc
   import rtc_pkg::*;
#(
   parameter int                    N_CAMPOS  = N_CAMPOS_DEF,
   parameter logic [8*N_CAMPOS-1:0] LIM_MAX   = LIM_MAX_DEF,
   parameter logic [8*N_CAMPOS-1:0] LIM_MIN   = LIM_MIN_DEF,
   parameter logic [N_CAMPOS-1:0]   HORA_MASK = HORA_MASK_DEF,
   parameter int                    REP_DELAY = 50_000_000,
   parameter int                    REP_RATE  = 10_000_000
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    en_escr,
   input  logic                    aumenta,
   input  logic                    disminuye,
   input  logic                    corre_der,
   input  logic                    corre_izq,
   input  logic                    doce_24,
   input  logic [8*N_CAMPOS-1:0]   rtc_in,
   input  logic                    wr_ack,
   output logic [8*N_CAMPOS-1:0]   campos_out,
   output logic [8*N_CAMPOS-1:0]   vga_out,
   output logic [N_CAMPOS-1:0]     pm_out,
   output logic [N_CAMPOS-1:0]     cursor,
   output logic                    wr_req
);

   estado_t               estado_q;
   logic [8*N_CAMPOS-1:0] campos_q;
   logic [8*N_CAMPOS-1:0] campos_d;
   logic [N_CAMPOS-1:0]   cursor_q;
   logic [N_CAMPOS-1:0]   cursor_d;
   logic                  wr_req_q;
   logic [8*N_CAMPOS-1:0] vga_q;
   logic [8*N_CAMPOS-1:0] vga_d;
   logic [N_CAMPOS-1:0]   pm_q;
   logic [N_CAMPOS-1:0]   pm_d;
   logic                  en_q;
   logic                  der_q;
   logic                  izq_q;

   logic       paso_aum;
   logic       paso_dis;
   logic       en_sube;
   logic       en_baja;
   logic       hacer_inc;
   logic       hacer_dec;
   logic       mover_izq;
   logic       mover_der;
   logic [7:0] fuente;
   logic [8:0] conv;

   repetidor_boton #(
      .REP_DELAY (REP_DELAY),
      .REP_RATE  (REP_RATE)
   ) u_rep_aum (
      .clk     (clk),
      .reset   (reset),
      .boton_i (aumenta),
      .paso_o  (paso_aum)
   );

   repetidor_boton #(
      .REP_DELAY (REP_DELAY),
      .REP_RATE  (REP_RATE)
   ) u_rep_dis (
      .clk     (clk),
      .reset   (reset),
      .boton_i (disminuye),
      .paso_o  (paso_dis)
   );

   // Edge decode. Whenever both step buttons are down nothing is stepped,
   // which covers simultaneous presses as well as suppressing auto-repeat.
   always_comb begin
      en_sube   = en_escr & ~en_q;
      en_baja   = ~en_escr & en_q;
      hacer_inc = paso_aum & ~(aumenta & disminuye);
      hacer_dec = paso_dis & ~(aumenta & disminuye);
      mover_izq = (corre_izq & ~izq_q) & ~(corre_der & ~der_q);
      mover_der = (corre_der & ~der_q) & ~(corre_izq & ~izq_q);
   end

   // Next field values and cursor while editing. The step uses the cursor
   // position from before any move requested in the same cycle.
   always_comb begin
      campos_d = campos_q;
      for (int i = 0; i < N_CAMPOS; i++) begin
         if (cursor_q[i]) begin
            if (hacer_inc)
               campos_d[8*i +: 8] = bcd_inc(campos_q[8*i +: 8],
                                            LIM_MIN[8*i +: 8], LIM_MAX[8*i +: 8]);
            else if (hacer_dec)
               campos_d[8*i +: 8] = bcd_dec(campos_q[8*i +: 8],
                                            LIM_MIN[8*i +: 8], LIM_MAX[8*i +: 8]);
         end
      end
      cursor_d = cursor_q;
      if (mover_izq)
         cursor_d = {cursor_q[N_CAMPOS-2:0], cursor_q[N_CAMPOS-1]};
      else if (mover_der)
         cursor_d = {cursor_q[0], cursor_q[N_CAMPOS-1:1]};
   end

   // Display source: edited values while editing, live RTC otherwise.
   always_comb begin
      vga_d  = '0;
      pm_d   = '0;
      fuente = '0;
      conv   = '0;
      for (int i = 0; i < N_CAMPOS; i++) begin
         fuente = (estado_q == EDIT) ? campos_q[8*i +: 8] : rtc_in[8*i +: 8];
         conv   = bcd_a_12h(fuente);
         if (HORA_MASK[i] && doce_24) begin
            vga_d[8*i +: 8] = conv[7:0];
            pm_d[i]         = conv[8];
         end else begin
            vga_d[8*i +: 8] = fuente;
         end
      end
   end

   // Editor FSM. An en_escr rise seen while committing is lost on purpose:
   // en_q tracks the switch in every state, so a new edit needs a fresh rise.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         estado_q <= IDLE;
         campos_q <= LIM_MIN;
         cursor_q <= '0;
         wr_req_q <= 1'b0;
         vga_q    <= '0;
         pm_q     <= '0;
         en_q     <= 1'b0;
         der_q    <= 1'b0;
         izq_q    <= 1'b0;
      end else begin
         en_q  <= en_escr;
         der_q <= corre_der;
         izq_q <= corre_izq;
         vga_q <= vga_d;
         pm_q  <= pm_d;
         case (estado_q)
            IDLE: begin
               if (en_sube) begin
                  campos_q <= rtc_in;
                  cursor_q <= N_CAMPOS'(1);
                  estado_q <= EDIT;
               end
            end
            EDIT: begin
               if (en_baja) begin
                  cursor_q <= '0;
                  wr_req_q <= 1'b1;
                  estado_q <= COMMIT;
               end else begin
                  campos_q <= campos_d;
                  cursor_q <= cursor_d;
               end
            end
            COMMIT: begin
               if (wr_ack) begin
                  wr_req_q <= 1'b0;
                  estado_q <= IDLE;
               end
            end
            default: begin
               cursor_q <= '0;
               wr_req_q <= 1'b0;
               estado_q <= IDLE;
            end
         endcase
      end
   end

   assign campos_out = campos_q;
   assign cursor     = cursor_q;
   assign wr_req     = wr_req_q;
   assign vga_out    = vga_q;
   assign pm_out     = pm_q;

endmodule
